// File: rtl/posit_quire_arbiter.sv
// Round-robin arbiter that serialises requester bursts into one shared posit quire MAC
// and routes each rounded result back to the requester that owned the burst.
module posit_quire_arbiter #(
    parameter int POSIT_WIDTH = 8,
    parameter int POSIT_ES    = 0,
    parameter int N_REQ       = 4,
    parameter int PIPE_LAT    = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ-1:0]             req_last,
    input  logic [N_REQ*POSIT_WIDTH-1:0] req_a,
    input  logic [N_REQ*POSIT_WIDTH-1:0] req_b,
    output logic                         unit_valid,
    output logic                         unit_first,
    output logic                         unit_last,
    output logic [POSIT_WIDTH-1:0]       unit_a,
    output logic [POSIT_WIDTH-1:0]       unit_b,
    input  logic                         unit_res_valid,
    input  logic [POSIT_WIDTH-1:0]       unit_res,
    output logic [N_REQ-1:0]             rsp_valid,
    output logic [POSIT_WIDTH-1:0]       rsp_data,
    output logic [$clog2(N_REQ)-1:0]     grant_id,
    output logic                         busy,
    output logic                         err
);

    localparam int IDW = $clog2(N_REQ);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    // POSIT_ES only travels with the operands; it is referenced here so bad sets are caught.
    if (N_REQ < 2 || N_REQ > 8 || PIPE_LAT < 1 || POSIT_ES < 0) begin : gBadParams
        $error("posit_quire_arbiter: unsupported parameter set");
    end

    logic [0:0]             state_q, state_d;
    logic [IDW-1:0]         rrPtr_q, rrPtr_d;
    logic [IDW-1:0]         lockId_q, lockId_d;
    logic [IDW-1:0]         candId;
    logic                   candFound;
    logic [IDW-1:0]         selId;
    logic                   xfer;
    logic                   xferLast;
    logic [POSIT_WIDTH-1:0] xferA, xferB;

    logic                   unitValid_q, unitValid_d;
    logic                   unitFirst_q, unitFirst_d;
    logic                   unitLast_q, unitLast_d;
    logic [POSIT_WIDTH-1:0] unitA_q, unitA_d;
    logic [POSIT_WIDTH-1:0] unitB_q, unitB_d;
    logic [IDW-1:0]         unitId_q, unitId_d;

    logic [PIPE_LAT-1:0]          tagValid_q;
    logic [PIPE_LAT-1:0][IDW-1:0] tagId_q;
    logic                         exitValid;
    logic [IDW-1:0]               exitId;
    logic                         rspHit;

    logic [N_REQ-1:0]       rspValid_q, rspValid_d;
    logic [POSIT_WIDTH-1:0] rspData_q, rspData_d;
    logic                   err_q, err_d;

    // Round-robin search starts just after the last requester that finished a burst.
    always_comb begin
        candId    = rrPtr_q;
        candFound = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!candFound && req_valid[(int'(rrPtr_q) + k) % N_REQ]) begin
                candFound = 1'b1;
                candId    = IDW'((int'(rrPtr_q) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        grant_id  = candId;
        if (state_q == BURST) begin
            req_ready[lockId_q] = 1'b1;
            grant_id            = lockId_q;
        end else if (candFound) begin
            req_ready[candId] = 1'b1;
        end
    end

    assign selId    = (state_q == BURST) ? lockId_q : candId;
    assign xfer     = req_valid[selId] & req_ready[selId];
    assign xferLast = req_last[selId];
    assign xferA    = req_a[int'(selId)*POSIT_WIDTH +: POSIT_WIDTH];
    assign xferB    = req_b[int'(selId)*POSIT_WIDTH +: POSIT_WIDTH];

    always_comb begin
        state_d  = state_q;
        rrPtr_d  = rrPtr_q;
        lockId_d = lockId_q;
        if (xfer) begin
            if (xferLast) begin
                state_d = IDLE;
                rrPtr_d = selId;
            end else if (state_q == IDLE) begin
                state_d  = BURST;
                lockId_d = selId;
            end
        end
    end

    always_comb begin
        unitValid_d = xfer;
        unitFirst_d = xfer & (state_q == IDLE);
        unitLast_d  = xfer & xferLast;
        unitA_d     = xfer ? xferA : unitA_q;
        unitB_d     = xfer ? xferB : unitB_q;
        unitId_d    = xfer ? selId : unitId_q;
    end

    assign exitValid = tagValid_q[PIPE_LAT-1];
    assign exitId    = tagId_q[PIPE_LAT-1];
    assign rspHit    = exitValid & unit_res_valid;

    // A result without a tag, or a tag without a result, is a MAC protocol violation.
    always_comb begin
        rspValid_d = '0;
        if (rspHit) begin
            rspValid_d[exitId] = 1'b1;
        end
        rspData_d = rspHit ? unit_res : rspData_q;
        err_d     = err_q | (exitValid ^ unit_res_valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rrPtr_q     <= IDW'(N_REQ - 1);
            lockId_q    <= '0;
            unitValid_q <= 1'b0;
            unitFirst_q <= 1'b0;
            unitLast_q  <= 1'b0;
            unitA_q     <= '0;
            unitB_q     <= '0;
            unitId_q    <= '0;
            tagValid_q  <= '0;
            tagId_q     <= '0;
            rspValid_q  <= '0;
            rspData_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rrPtr_q     <= rrPtr_d;
            lockId_q    <= lockId_d;
            unitValid_q <= unitValid_d;
            unitFirst_q <= unitFirst_d;
            unitLast_q  <= unitLast_d;
            unitA_q     <= unitA_d;
            unitB_q     <= unitB_d;
            unitId_q    <= unitId_d;
            for (int k = PIPE_LAT - 1; k > 0; k--) begin
                tagValid_q[k] <= tagValid_q[k-1];
                tagId_q[k]    <= tagId_q[k-1];
            end
            tagValid_q[0] <= unitValid_q & unitLast_q;
            tagId_q[0]    <= unitId_q;
            rspValid_q    <= rspValid_d;
            rspData_q     <= rspData_d;
            err_q         <= err_d;
        end
    end

    assign unit_valid = unitValid_q;
    assign unit_first = unitFirst_q;
    assign unit_last  = unitLast_q;
    assign unit_a     = unitA_q;
    assign unit_b     = unitB_q;
    assign rsp_valid  = rspValid_q;
    assign rsp_data   = rspData_q;
    assign err        = err_q;
    assign busy       = (state_q == BURST) | (|tagValid_q);

endmodule

// File: doc/posit_quire_arbiter.md
POSIT_QUIRE_ARBITER -- requirements
Module: posit_quire_arbiter

Interface
REQ-001 SHALL have parameter POSIT_WIDTH, default 8, posit word width in bits.
REQ-002 SHALL have parameter POSIT_ES, default 0, exponent field width; passed through only, not used internally.
REQ-003 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-004 SHALL have parameter PIPE_LAT, default 3, fixed latency in cycles from unit_valid&unit_last to unit_res_valid (>=1).
REQ-005 SHALL have port clk  in  1  single clock, rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports req_valid / req_ready / req_last  in/out/in  N_REQ each  per-requester beat handshake and end-of-burst flag.
REQ-008 SHALL have ports req_a, req_b  in  N_REQ*POSIT_WIDTH each  packed operand pairs; requester i occupies bits [i*POSIT_WIDTH +: POSIT_WIDTH].
REQ-009 SHALL have ports unit_valid, unit_first, unit_last  out  1 each  beat strobe, quire clear, quire round-out.
REQ-010 SHALL have ports unit_a, unit_b  out  POSIT_WIDTH each  operands to the shared quire MAC.
REQ-011 SHALL have ports unit_res_valid  in  1  and  unit_res  in  POSIT_WIDTH  rounded result from the MAC.
REQ-012 SHALL have ports rsp_valid  out  N_REQ  (one-hot pulse) and rsp_data  out  POSIT_WIDTH.
REQ-013 SHALL have ports grant_id  out  $clog2(N_REQ)  current owner; busy  out  1  (state==BURST or any tag pending); err  out  1  sticky protocol error.

Function
REQ-014 SHALL implement FSM states IDLE and BURST.
REQ-015 In IDLE, SHALL assert req_ready for exactly one requester: first asserted req_valid searching round-robin from rr_ptr+1 (mod N_REQ); no ready when no req_valid.
REQ-016 A transfer SHALL occur when req_valid[g]&req_ready[g]; a transfer in IDLE with req_last=0 SHALL move to BURST, locked to g.
REQ-017 In BURST, SHALL assert req_ready only for the locked requester; all others see 0 regardless of req_valid.
REQ-018 A transfer with req_last=1 SHALL return to IDLE and set rr_ptr=g; a single-beat burst (last on first beat) SHALL stay in IDLE and set rr_ptr=g.
REQ-019 Each transfer SHALL be registered to the unit: next cycle unit_valid=1, unit_a/unit_b=operands, unit_last=req_last, unit_first=1 iff the beat was first of its burst.
REQ-020 No transfer SHALL give unit_valid=0 next cycle; unit_a/unit_b hold their previous values.
REQ-021 SHALL hold a PIPE_LAT-deep tag shift register of {valid,id}, pushed on unit_valid&unit_last, advancing every cycle.
REQ-022 When the tag exiting the shift register is valid and unit_res_valid=1, next cycle SHALL pulse rsp_valid[id]=1 for one cycle with rsp_data=unit_res.
REQ-023 Exiting tag valid with unit_res_valid=0, or unit_res_valid=1 with no valid exiting tag, SHALL set err=1 until reset; a response SHALL NOT be issued in either case.
REQ-024 Last-handshake to rsp_valid latency SHALL be exactly PIPE_LAT+2 cycles; back-to-back bursts SHALL be sustainable at one beat per cycle.
REQ-025 grant_id SHALL show the locked id in BURST and the IDLE candidate (or rr_ptr when none) in IDLE.
REQ-026 req_ready SHALL depend only on state, rr_ptr, lock and req_valid (no dependency on unit_res_valid).

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, rr_ptr=N_REQ-1, tag register cleared, unit_valid=unit_first=unit_last=0, unit_a=unit_b=0, rsp_valid=0, rsp_data=0, err=0, busy=0.
REQ-028 Reset mid-burst or with tags pending SHALL discard them; no rsp_valid SHALL follow for those bursts after release.

Verification
REQ-029 All 4 requesters valid with single-beat last after reset -> grants in order 0,1,2,3,0, one per cycle; rsp_valid[0] 5 cycles after first handshake.
REQ-030 Requester 1 sends 3-beat burst while 2 holds valid -> req_ready[2]=0 for all 3 beats; unit_first on beat 1 only, unit_last on beat 3; requester 2 granted the cycle after.
REQ-031 Model MAC returns unit_res=8'h40 PIPE_LAT cycles after last -> rsp_valid[1] pulse, rsp_data=8'h40, others 0.
REQ-032 unit_res_valid injected with no pending tag -> err=1, no rsp_valid, err stays 1 until rst_n low.
REQ-033 rst_n low during beat 2 of a 4-beat burst -> outputs at reset values immediately; after release requester 0 granted first, no stale response.
